// File: rtl/sdram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// The grant is held for a whole cyc; a watchdog aborts cycles the slave never acks.
module sdram_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLKOUT,
  input  logic              rst_n,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_addr_i,
  input  logic [DW-1:0]     m0_data_i,
  output logic [DW-1:0]     m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_stall_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_addr_i,
  input  logic [DW-1:0]     m1_data_i,
  output logic [DW-1:0]     m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_stall_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW-1:0]     s_data_o,
  input  logic [DW-1:0]     s_data_i,
  input  logic              s_ack_i,
  input  logic              s_stall_i,
  output logic [1:0]        grant
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic          owner, owner_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          err0_nxt, err1_nxt;
  logic          own_cyc;

  // owner stays valid through ABORT so the abort knows whom to release
  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      timer    <= '0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      owner    <= owner_nxt;
      timer    <= timer_nxt;
      m0_err_o <= err0_nxt;
      m1_err_o <= err1_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
    timer_nxt = timer;
    err0_nxt  = 1'b0;
    err1_nxt  = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        // on a tie, last==1 means m1 was served last, so m0 wins
        if (m0_cyc_i && (!m1_cyc_i || last)) begin
          state_nxt = GNT0;
          owner_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
          owner_nxt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else if (s_ack_i) begin
          timer_nxt = '0;
        end else if (timer == TLAST) begin
          state_nxt = ABORT;
          err0_nxt  = ~owner;
          err1_nxt  = owner;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_addr_o   = '0;
    s_data_o   = '0;
    m0_data_o  = '0;
    m0_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_data_o  = '0;
    m1_ack_o   = 1'b0;
    m1_stall_o = 1'b1;
    grant      = 2'b00;
    case (state)
      GNT0: begin
        grant      = 2'b01;
        s_cyc_o    = 1'b1;
        s_stb_o    = m0_stb_i;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_addr_o   = m0_addr_i;
        s_data_o   = m0_data_i;
        m0_data_o  = s_data_i;
        m0_ack_o   = s_ack_i;
        m0_stall_o = s_stall_i;
      end
      GNT1: begin
        grant      = 2'b10;
        s_cyc_o    = 1'b1;
        s_stb_o    = m1_stb_i;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_addr_o   = m1_addr_i;
        s_data_o   = m1_data_i;
        m1_data_o  = s_data_i;
        m1_ack_o   = s_ack_i;
        m1_stall_o = s_stall_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter: arbitration, forwarding, watchdog and async reset.
module tb_sdram_wb_arbiter;

  logic        CLKOUT = 1'b0;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_stall_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_stall_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i, s_stall_i;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;
  int hi;
  int errs;

  sdram_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(64)) dut (
    .CLKOUT(CLKOUT), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .s_stall_i(s_stall_i), .grant(grant)
  );

  always #5 CLKOUT = ~CLKOUT;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLKOUT);
    #1;
  endtask

  task automatic smp();
    @(negedge CLKOUT);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hF; m0_addr_i = 0; m0_data_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'hF; m1_addr_i = 0; m1_data_i = 0;
    s_data_i = 0; s_ack_i = 0; s_stall_i = 0;

    // reset state
    repeat (2) @(posedge CLKOUT);
    smp();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_m0_stall", 32'(m0_stall_o), 32'h1);
    chk("rst_m0_err", 32'(m0_err_o), 32'h0);
    nxt(); rst_n = 1'b1; smp();

    // m0 single write, slave acks five cycles after it first sees stb
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 32'h10; m0_data_i = 32'hA5A5A5A5;
    smp();
    chk("w_s_cyc_lat", 32'(s_cyc_o), 32'h0);
    chk("w_grant_lat", 32'(grant), 32'h0);
    nxt(); smp();
    chk("w_s_cyc", 32'(s_cyc_o), 32'h1);
    chk("w_grant", 32'(grant), 32'h1);
    chk("w_s_addr", s_addr_o, 32'h10);
    chk("w_s_data", s_data_o, 32'hA5A5A5A5);
    chk("w_s_we", 32'(s_we_o), 32'h1);
    chk("w_m1_stall", 32'(m1_stall_o), 32'h1);
    chk("w_m0_stall", 32'(m0_stall_o), 32'h0);
    repeat (4) begin nxt(); smp(); end
    chk("w_m0_ack_pre", 32'(m0_ack_o), 32'h0);
    nxt(); s_ack_i = 1; smp();
    chk("w_m0_ack", 32'(m0_ack_o), 32'h1);
    chk("w_m1_ack", 32'(m1_ack_o), 32'h0);
    nxt(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; smp();
    chk("w_rel_s_cyc", 32'(s_cyc_o), 32'h1);
    chk("w_rel_ack", 32'(m0_ack_o), 32'h0);
    nxt(); smp();
    chk("w_idle_grant", 32'(grant), 32'h0);
    chk("w_idle_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("w_idle_addr", s_addr_o, 32'h0);

    // tie after reset: m0 first, then m1; repeated tie goes back to m0
    nxt(); rst_n = 0; smp();
    nxt(); rst_n = 1; smp();
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h200;
    smp();
    chk("t_grant_lat", 32'(grant), 32'h0);
    nxt(); s_ack_i = 1; s_data_i = 32'hDEADBEEF; smp();
    chk("t_grant0", 32'(grant), 32'h1);
    chk("t_s_addr0", s_addr_o, 32'h100);
    chk("t_m1_stall", 32'(m1_stall_o), 32'h1);
    chk("t_m1_ack", 32'(m1_ack_o), 32'h0);
    chk("t_m1_data", m1_data_o, 32'h0);
    chk("t_m0_data", m0_data_o, 32'hDEADBEEF);
    nxt(); s_ack_i = 0; s_data_i = 0; m0_cyc_i = 0; m0_stb_i = 0; smp();
    chk("t_m1_stall_rel", 32'(m1_stall_o), 32'h1);
    nxt(); smp();
    chk("t_gap_grant", 32'(grant), 32'h0);
    chk("t_gap_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("t_gap_m1_stall", 32'(m1_stall_o), 32'h1);
    nxt(); smp();
    chk("t_grant1", 32'(grant), 32'h2);
    chk("t_s_addr1", s_addr_o, 32'h200);
    chk("t_m1_stall_own", 32'(m1_stall_o), 32'h0);
    nxt(); m1_cyc_i = 0; m1_stb_i = 0; smp();
    nxt(); smp();
    chk("t_idle2", 32'(grant), 32'h0);
    nxt(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; smp();
    nxt(); smp();
    chk("t_rr_grant0", 32'(grant), 32'h1);
    chk("t_rr_m1_stall", 32'(m1_stall_o), 32'h1);
    nxt(); m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; smp();
    nxt(); smp();
    chk("t_idle3", 32'(grant), 32'h0);

    // m1 read while m0 idle
    nxt(); m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_addr_i = 32'h5; smp();
    nxt(); smp();
    chk("r_grant", 32'(grant), 32'h2);
    chk("r_s_addr", s_addr_o, 32'h5);
    chk("r_s_we", 32'(s_we_o), 32'h0);
    nxt(); s_ack_i = 1; s_data_i = 32'h12345678; smp();
    chk("r_m1_data", m1_data_o, 32'h12345678);
    chk("r_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("r_m0_data", m0_data_o, 32'h0);
    chk("r_m0_ack", 32'(m0_ack_o), 32'h0);
    nxt(); s_ack_i = 0; s_data_i = 0; m1_cyc_i = 0; m1_stb_i = 0; smp();
    nxt(); smp();
    chk("r_idle", 32'(grant), 32'h0);

    // watchdog: m0 never acked, m1 waiting behind it
    nxt(); m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 32'h40; smp();
    hi = 0; errs = 0;
    for (int i = 0; i < 64; i++) begin
      nxt();
      if (i == 0) begin m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h80; end
      smp();
      hi += int'(s_cyc_o);
      errs += int'(m0_err_o);
    end
    chk("to_cyc_high_cycles", 32'(hi), 32'd64);
    chk("to_no_early_err", 32'(errs), 32'd0);
    nxt(); smp();
    chk("to_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("to_s_stb", 32'(s_stb_o), 32'h0);
    chk("to_err", 32'(m0_err_o), 32'h1);
    chk("to_m1_err", 32'(m1_err_o), 32'h0);
    chk("to_stall", 32'(m0_stall_o), 32'h1);
    chk("to_grant", 32'(grant), 32'h0);
    nxt(); smp();
    chk("to_err_once", 32'(m0_err_o), 32'h0);
    chk("to_hold_cyc", 32'(s_cyc_o), 32'h0);
    nxt(); m0_cyc_i = 0; m0_stb_i = 0; smp();
    chk("to_abort_grant", 32'(grant), 32'h0);
    nxt(); smp();
    chk("to_idle_grant", 32'(grant), 32'h0);
    nxt(); smp();
    chk("to_m1_granted", 32'(grant), 32'h2);
    chk("to_m1_addr", s_addr_o, 32'h80);
    nxt(); m1_cyc_i = 0; m1_stb_i = 0; smp();
    nxt(); smp();

    // ack in the cycle the timer would expire wins, and clears the timer
    nxt(); m0_cyc_i = 1; m0_stb_i = 1; smp();
    hi = 0; errs = 0;
    for (int i = 0; i < 63; i++) begin
      nxt(); smp();
      hi += int'(s_cyc_o);
    end
    nxt(); s_ack_i = 1; smp();
    chk("ae_ack", 32'(m0_ack_o), 32'h1);
    chk("ae_s_cyc", 32'(s_cyc_o), 32'h1);
    for (int i = 0; i < 62; i++) begin
      nxt();
      if (i == 0) s_ack_i = 0;
      smp();
      hi += int'(s_cyc_o);
      errs += int'(m0_err_o);
    end
    chk("ae_cyc_held", 32'(hi), 32'd125);
    chk("ae_no_err", 32'(errs), 32'd0);
    nxt(); m0_cyc_i = 0; m0_stb_i = 0; smp();
    chk("ae_rel_s_cyc", 32'(s_cyc_o), 32'h1);
    nxt(); smp();
    chk("ae_idle_grant", 32'(grant), 32'h0);
    chk("ae_idle_err", 32'(m0_err_o), 32'h0);

    // asynchronous reset mid-grant, then the tie goes to m0 again
    nxt(); m0_cyc_i = 1; m0_stb_i = 1; smp();
    nxt(); smp();
    chk("ar_grant_pre", 32'(grant), 32'h1);
    #2 rst_n = 0;
    #1;
    chk("ar_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("ar_grant", 32'(grant), 32'h0);
    m1_cyc_i = 1; m1_stb_i = 1;
    nxt(); rst_n = 1; smp();
    chk("ar_idle", 32'(grant), 32'h0);
    nxt(); smp();
    chk("ar_tie_m0", 32'(grant), 32'h1);
    nxt(); m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; smp();
    nxt(); smp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in front of the SDRAM controller.
- Lets the USB-FIFO-to-SDRAM writer path (master 0) and the ConvNet feature/weight fetch path (master 1) share the single SDRAM Wishbone port.
- Round-robin grant, held for the whole bus cycle (cyc), with a watchdog that aborts a stalled cycle and reports an error to the owning master.
- Sits between the masters and the SDRAM controller's Wishbone slave port, clocked by the FX2 CLKOUT domain.

Parameters:
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TIMEOUT, 64, cycles without s_ack_i inside a granted cycle before abort (>=2)

Ports:
CLKOUT  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
m0_cyc_i, m1_cyc_i  input  1  master bus-cycle request
m0_stb_i, m1_stb_i  input  1  master strobe
m0_we_i, m1_we_i  input  1  master write enable
m0_sel_i, m1_sel_i  input  DW/8  byte selects
m0_addr_i, m1_addr_i  input  AW  address
m0_data_i, m1_data_i  input  DW  write data
m0_data_o, m1_data_o  output  DW  read data to master
m0_ack_o, m1_ack_o  output  1  ack to master
m0_stall_o, m1_stall_o  output  1  stall to master
m0_err_o, m1_err_o  output  1  one-cycle abort pulse
s_cyc_o, s_stb_o, s_we_o  output  1  to SDRAM slave
s_sel_o  output  DW/8  to SDRAM slave
s_addr_o  output  AW  to SDRAM slave
s_data_o  output  DW  write data to slave
s_data_i  input  DW  read data from slave
s_ack_i, s_stall_i  input  1  slave ack / stall
grant  output  2  one-hot current owner (bit0 = m0), 0 when idle

Behaviour:
- Reset (async, rst_n=0): state IDLE, grant=0, last-served pointer = 1 (so m0 wins the first tie), timer=0, err pulses=0. All slave outputs are 0 immediately, including mid-cycle.
- States: IDLE, GNT0, GNT1, ABORT.
- IDLE:
  - If exactly one cyc is high, go to that master's GNT state.
  - If both are high, grant the master not equal to last-served.
  - The grant is registered: s_cyc_o rises one cycle after m*_cyc_i is first seen high.
- GNTn (owner n):
  - s_cyc_o = 1.
  - s_stb_o, s_we_o, s_sel_o, s_addr_o and s_data_o are combinational copies of master n's inputs.
  - mn_ack_o = s_ack_i, mn_stall_o = s_stall_i, mn_data_o = s_data_i.
- Non-owner, in every state: stall_o=1, ack_o=0, data_o=0. Its request waits and is never dropped.
- Release: when mn_cyc_i=0 in GNTn, go to IDLE and set last-served=n.
  - At least one idle cycle (s_cyc_o=0) separates consecutive grants.
  - A pending other master is granted in the cycle after IDLE.
- Timer:
  - Cleared on entry to GNTn and on every s_ack_i=1.
  - Increments each GNTn cycle otherwise.
  - When it reaches TIMEOUT-1 with no ack, go to ABORT.
- ABORT:
  - s_cyc_o=0, s_stb_o=0, mn_stall_o=1.
  - mn_err_o=1 for exactly the first ABORT cycle.
  - Stay until mn_cyc_i=0, then go to IDLE with last-served=n.
- An ack arriving in the same cycle the timer would expire wins: the ack is forwarded, the timer clears and there is no abort.
- mn_cyc_i dropping in the same cycle as s_ack_i: the ack is forwarded, then the release proceeds normally.
- cyc high with stb low is legal; the grant is held and the timer runs.
- grant mirrors the state (GNT0 gives 01, GNT1 gives 10, IDLE/ABORT give 00).

Test Plan:
- Reset then m0 single write (addr 0x10, data 0xA5A5A5A5, slave acks 5 cycles after stb) -> s_cyc_o high 1 cycle after m0_cyc_i; slave sees addr 0x10 and data 0xA5A5A5A5; m0_ack_o pulses with s_ack_i; grant=01, then 00 after m0 releases.
- m0 and m1 raise cyc on the same edge after reset -> m0 granted first; m1_stall_o=1 throughout; after m0 releases, 1 idle cycle, then grant=10. Repeat the tie -> m1 loses, m0 granted (round-robin alternates).
- m1 read from addr 0x05 while m0 idle, slave returns s_data_i=0x12345678 with ack -> m1_data_o=0x12345678 during ack; m0_data_o=0, m0_ack_o=0.
- m0 granted, slave never acks, TIMEOUT=64 -> at cycle 64 of the grant s_cyc_o falls, m0_err_o is high for exactly 1 cycle, state holds ABORT until m0_cyc_i=0; a pending m1 is then granted.
- Ack at exactly cycle TIMEOUT-1 -> no err, transfer completes, timer clears.
- rst_n pulled low mid-grant with m0 active -> s_cyc_o and grant drop to 0 asynchronously; after release m0 is again first to be granted on a tie.
